// File: rtl/t_ff_bank.sv
`default_nettype none
// ============================================================================
// Module   : t_ff_bank
// Purpose  : Bank of WIDTH T flip-flops sharing one clock. Operates as
//            independent per-bit toggles, a masked up-counter or a masked
//            down-counter. Also provides parallel load, a combinational
//            terminal-count flag and a registered change pulse.
// Options  : TFF_PARITY_EN adds a registered parity output par, where par == ^q.
// Revision : 1.0  initial release
// ============================================================================
module t_ff_bank #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] t,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             chg
`ifdef TFF_PARITY_EN
    ,
    output logic             par
`endif
);

    localparam logic [1:0] C_MODE_TOGGLE = 2'b00;
    localparam logic [1:0] C_MODE_UP     = 2'b01;
    localparam logic [1:0] C_MODE_DOWN   = 2'b10;

    logic [WIDTH-1:0] r_q;
    logic             r_chg;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_borrow;

    // The carry and borrow chains are built from the unmasked q. A stage that
    // is masked off by t still gates every stage above it.
    assign w_carry[0]  = 1'b1;
    assign w_borrow[0] = 1'b1;

    generate
        for (genvar i = 1; i < WIDTH; i++) begin : g_chain
            assign w_carry[i]  = w_carry[i-1]  &  r_q[i-1];
            assign w_borrow[i] = w_borrow[i-1] & ~r_q[i-1];
        end
    endgenerate

    // Next-state select. Load takes priority over toggling and counting.
    // Mode 11 holds the state.
    always_comb begin
        w_q_next = r_q;
        if (load) begin
            w_q_next = d;
        end else if (en) begin
            case (mode)
                C_MODE_TOGGLE: w_q_next = r_q ^ t;
                C_MODE_UP:     w_q_next = r_q ^ (t & w_carry);
                C_MODE_DOWN:   w_q_next = r_q ^ (t & w_borrow);
                default:       w_q_next = r_q;
            endcase
        end
    end

    // Terminal count is decoded directly from the current state and inputs.
    always_comb begin
        tc = 1'b0;
        if (en) begin
            case (mode)
                C_MODE_TOGGLE: tc = (t != '0) && ((r_q ^ t) == '0);
                C_MODE_UP:     tc = (r_q == {WIDTH{1'b1}});
                C_MODE_DOWN:   tc = (r_q == '0);
                default:       tc = 1'b0;
            endcase
        end
    end

    // State register and change pulse. Reset clears chg even when q already
    // holds RST_VAL.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q   <= RST_VAL;
            r_chg <= 1'b0;
        end else begin
            r_q   <= w_q_next;
            r_chg <= (w_q_next != r_q);
        end
    end

`ifdef TFF_PARITY_EN
    logic r_par;

    // Parity is registered from the next state, so it tracks q on every cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_par <= ^RST_VAL;
        end else begin
            r_par <= ^w_q_next;
        end
    end

    assign par = r_par;
`endif

    assign q   = r_q;
    assign chg = r_chg;

endmodule
`default_nettype wire

// File: tb/tb_t_ff_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_t_ff_bank
// Purpose  : Directed self-checking bench for t_ff_bank (WIDTH=4, RST_VAL=0).
// Revision : 1.0  initial release
// ============================================================================
module tb_t_ff_bank;

    localparam int C_WIDTH = 4;

    logic               clk;
    logic               rst;
    logic [C_WIDTH-1:0] t;
    logic               en;
    logic [1:0]         mode;
    logic               load;
    logic [C_WIDTH-1:0] d;
    logic [C_WIDTH-1:0] q;
    logic               tc;
    logic               chg;
`ifdef TFF_PARITY_EN
    logic               par;
`endif

    int n_checks = 0;
    int n_errors = 0;

    t_ff_bank #(
        .WIDTH   (C_WIDTH),
        .RST_VAL (4'b0000)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .t    (t),
        .en   (en),
        .mode (mode),
        .load (load),
        .d    (d),
        .q    (q),
        .tc   (tc),
        .chg  (chg)
`ifdef TFF_PARITY_EN
        ,
        .par  (par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the registered outputs against the values worked out by hand.
    task automatic expect_state(input string tag, input logic [3:0] exp_q, input logic exp_chg);
        check({tag, ".q"}, {28'd0, q}, {28'd0, exp_q});
        check({tag, ".chg"}, {31'd0, chg}, {31'd0, exp_chg});
`ifdef TFF_PARITY_EN
        check({tag, ".par"}, {31'd0, par}, {31'd0, ^exp_q});
`endif
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; en = 1'b0; mode = 2'b00; t = 4'b0000; d = 4'b0000;
        tick();
        tick();
        expect_state("reset", 4'b0000, 1'b0);
        check("reset.tc", {31'd0, tc}, 32'd0);

        // Parallel toggle with t=1010 applied twice.
        rst = 1'b1; en = 1'b1; mode = 2'b00; t = 4'b1010;
        tick();
        expect_state("tog1", 4'b1010, 1'b1);
        check("tog1.tc", {31'd0, tc}, 32'd1);
        tick();
        expect_state("tog2", 4'b0000, 1'b1);
        check("tog2.tc", {31'd0, tc}, 32'd0);

        // Load, then count up through the wrap.
        en = 1'b0; load = 1'b1; d = 4'b1110;
        tick();
        expect_state("load1110", 4'b1110, 1'b1);
        load = 1'b0; mode = 2'b01; t = 4'b1111; en = 1'b1;
        tick();
        expect_state("up1", 4'b1111, 1'b1);
        check("up1.tc", {31'd0, tc}, 32'd1);
        tick();
        expect_state("upwrap", 4'b0000, 1'b1);
        check("upwrap.tc", {31'd0, tc}, 32'd0);

        // Masked up-count where bit1 is masked and bit2 toggles on the carry.
        load = 1'b1; d = 4'b0011;
        tick();
        expect_state("load0011", 4'b0011, 1'b1);
        load = 1'b0; mode = 2'b01; t = 4'b1101; en = 1'b1;
        tick();
        expect_state("masked_up", 4'b0110, 1'b1);

        // Down-count from zero, wrapping to all ones.
        load = 1'b1; d = 4'b0000;
        tick();
        expect_state("load0000", 4'b0000, 1'b1);
        load = 1'b0; mode = 2'b10; t = 4'b1111; en = 1'b1;
        #1;
        check("down.tc_pre", {31'd0, tc}, 32'd1);
        tick();
        expect_state("down1", 4'b1111, 1'b1);
        check("down1.tc", {31'd0, tc}, 32'd0);
        tick();
        expect_state("down2", 4'b1110, 1'b1);

        // Load wins over counting, and reset wins over load.
        load = 1'b1; d = 4'b0101; en = 1'b1; mode = 2'b01;
        tick();
        expect_state("load_wins", 4'b0101, 1'b1);
        rst = 1'b0;
        tick();
        expect_state("rst_wins", 4'b0000, 1'b0);

        // Hold in mode 11, then hold with en=0.
        rst = 1'b1; load = 1'b1; d = 4'b1001;
        tick();
        expect_state("load1001", 4'b1001, 1'b1);
        load = 1'b0; mode = 2'b11; t = 4'b1111; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_state("hold_m11", 4'b1001, 1'b0);
            check("hold_m11.tc", {31'd0, tc}, 32'd0);
        end
        mode = 2'b01; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_state("hold_en0", 4'b1001, 1'b0);
            check("hold_en0.tc", {31'd0, tc}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
